product_accumulator: RTL



---
 rtl/pacc_pkg.sv | 18 +
 rtl/product_accumulator_if.sv | 30 +++
 rtl/pacc_sat_add.sv | 27 ++
 rtl/product_accumulator.sv | 132 +++++++++++++
 4 files changed

// File: rtl/pacc_pkg.sv
// Shared types and constants for the product accumulator.
// Holds the FSM state encoding, the product width and the burst-length limit helper.
package pacc_pkg;

  localparam int PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } pacc_state_e;

  // Longest burst a CNT_W-bit beat counter can describe.
  function automatic int unsigned max_count(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / result-out handshake bundle for product_accumulator.
// The slave modport is the accumulator's view; master is the producer/consumer side.
interface product_accumulator_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
) ();
  import pacc_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              overflow;

  modport slave (
    input  in_valid, in_prod, in_last, clear, out_ready,
    output in_ready, out_valid, out_sum, out_count, overflow
  );

  modport master (
    output in_valid, in_prod, in_last, clear, out_ready,
    input  in_ready, out_valid, out_sum, out_count, overflow
  );

endinterface

// File: rtl/pacc_sat_add.sv
// Adds an 8-bit unsigned product to the ACC_W-bit running sum and reports the carry.
// Build option PACC_SAT_EN: clamp the sum to all-ones on carry instead of wrapping.
module pacc_sat_add
  import pacc_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] full;

  always_comb begin
    full  = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    carry = full[ACC_W];
`ifdef PACC_SAT_EN
    // Once clamped, every further add carries again, so the sum stays pinned.
    sum   = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    sum   = full[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a burst of multiplier products and presents one registered result per burst.
// Saturating arithmetic is selected at build time with PACC_SAT_EN (see pacc_sat_add).
//
//   state | meaning
//   IDLE  | no beat of the current burst accepted yet
//   ACCUM | at least one beat accepted, burst still open
//   HOLD  | result presented on out_*, waiting for out_ready
module product_accumulator
  import pacc_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  product_accumulator_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(max_count(CNT_W));

  pacc_state_e      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic             in_ready;
  logic             accept;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic [CNT_W-1:0] cnt_inc;
  logic             close_burst;

  pacc_sat_add #(.ACC_W(ACC_W)) u_add (
    .acc   (acc_q),
    .prod  (bus.in_prod),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign in_ready    = (state_q != HOLD) && !bus.clear && !rst;
  assign accept      = bus.in_valid && in_ready;
  assign cnt_inc     = cnt_q + 1'b1;
  // Hitting the counter limit closes the burst exactly as in_last would.
  assign close_burst = bus.in_last || (cnt_inc == CNT_MAX);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (bus.clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
      out_sum_d   = '0;
      out_count_d = '0;
      out_ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_d = add_sum;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | add_carry;
            if (close_burst) begin
              state_d     = HOLD;
              out_valid_d = 1'b1;
              out_sum_d   = add_sum;
              out_count_d = cnt_inc;
              out_ovf_d   = ovf_q | add_carry;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_d     = IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
            out_sum_d   = '0;
            out_count_d = '0;
            out_ovf_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign bus.overflow  = out_ovf_q;

endmodule
